// File: rtl/stap_chain_ctrl_if.sv
// Primary/secondary JTAG signal bundle for stap_chain_ctrl.
// The controller connects through the slave modport; the driving environment uses master.
interface stap_chain_ctrl_if #(
    parameter int unsigned NUM_STAP = 4,
    parameter int unsigned CFG_W    = 8
);
    logic                TMS;
    logic                TDI;
    logic [CFG_W-1:0]    config_reg;
    logic [NUM_STAP-1:0] STDO;
    logic                TDO;
    logic [NUM_STAP-1:0] STCK;
    logic [NUM_STAP-1:0] STMS;
    logic [NUM_STAP-1:0] STDI;
    logic [NUM_STAP-1:0] STRST_N;
    logic [NUM_STAP-1:0] active_mask;
    logic [3:0]          tap_state;
    logic                pending;

    modport master (
        output TMS, TDI, config_reg, STDO,
        input  TDO, STCK, STMS, STDI, STRST_N, active_mask, tap_state, pending
    );

    modport slave (
        input  TMS, TDI, config_reg, STDO,
        output TDO, STCK, STMS, STDI, STRST_N, active_mask, tap_state, pending
    );
endinterface

// File: rtl/stap_chain_ctrl.sv
// Secondary-TAP chain controller: tracks the primary TAP and re-forms the STAP daisy chain at TLR/RTI.
// Optional macro STAP_RST_PULSE_EN adds a per-channel STRST_N pulse when a channel joins.
module stap_chain_ctrl #(
    parameter int unsigned NUM_STAP = 4,
    parameter int unsigned CFG_W    = 8,
    parameter int unsigned RST_CYC  = 4
) (
    input  logic               TCK,
    input  logic               TRST,
    stap_chain_ctrl_if.slave   jtag
);

    if (NUM_STAP < 1 || NUM_STAP > CFG_W || RST_CYC < 1) begin : g_param_err
        $error("stap_chain_ctrl: illegal NUM_STAP/CFG_W/RST_CYC");
    end

    typedef enum logic [3:0] {
        TLR     = 4'hF, RTI     = 4'hC,
        SEL_DR  = 4'h7, CAP_DR  = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
        PAU_DR  = 4'h3, EX2_DR  = 4'h0, UPD_DR = 4'h5,
        SEL_IR  = 4'h4, CAP_IR  = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
        PAU_IR  = 4'hB, EX2_IR  = 4'h8, UPD_IR = 4'hD
    } tap_state_e;

    tap_state_e          state_q, state_d;
    logic                safe_c, shift_c, capture_c;
    logic [NUM_STAP-1:0] req_mask, commit_q, commit_d, active_c;
    logic [NUM_STAP-1:0] stdi_c, stms_c, strst_n_c;
    logic                tdo_c, bypass_q;

    assign req_mask = jtag.config_reg[NUM_STAP-1:0];

    // TAP tracker state register
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) state_q <= TLR;
        else      state_q <= state_d;
    end

    // IEEE 1149.1 next-state function
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:    state_d = jtag.TMS ? TLR    : RTI;
            RTI:    state_d = jtag.TMS ? SEL_DR : RTI;
            SEL_DR: state_d = jtag.TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_d = jtag.TMS ? EX1_DR : SH_DR;
            SH_DR:  state_d = jtag.TMS ? EX1_DR : SH_DR;
            EX1_DR: state_d = jtag.TMS ? UPD_DR : PAU_DR;
            PAU_DR: state_d = jtag.TMS ? EX2_DR : PAU_DR;
            EX2_DR: state_d = jtag.TMS ? UPD_DR : SH_DR;
            UPD_DR: state_d = jtag.TMS ? SEL_DR : RTI;
            SEL_IR: state_d = jtag.TMS ? TLR    : CAP_IR;
            CAP_IR: state_d = jtag.TMS ? EX1_IR : SH_IR;
            SH_IR:  state_d = jtag.TMS ? EX1_IR : SH_IR;
            EX1_IR: state_d = jtag.TMS ? UPD_IR : PAU_IR;
            PAU_IR: state_d = jtag.TMS ? EX2_IR : PAU_IR;
            EX2_IR: state_d = jtag.TMS ? UPD_IR : SH_IR;
            UPD_IR: state_d = jtag.TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // State decode used by commit and bypass logic
    always_comb begin
        safe_c    = 1'b0;
        shift_c   = 1'b0;
        capture_c = 1'b0;
        case (state_q)
            TLR, RTI:       safe_c    = 1'b1;
            SH_DR, SH_IR:   shift_c   = 1'b1;
            CAP_DR, CAP_IR: capture_c = 1'b1;
            default: ;
        endcase
    end

    assign commit_d = safe_c ? req_mask : commit_q;

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) commit_q <= '0;
        else      commit_q <= commit_d;
    end

    // One-bit bypass keeps the primary chain length at 1 when no STAP is connected
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            bypass_q <= 1'b0;
        end else if (active_c == '0) begin
            if (capture_c)    bypass_q <= 1'b0;
            else if (shift_c) bypass_q <= jtag.TDI;
        end
    end

`ifdef STAP_RST_PULSE_EN
    localparam int unsigned CNT_W = $clog2(RST_CYC + 1);

    logic [CNT_W-1:0]    cnt_q [NUM_STAP];
    logic [NUM_STAP-1:0] joined_q;

    // A newly committed channel is pulsed, then joins the chain at the next safe state
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            for (int i = 0; i < NUM_STAP; i++) cnt_q[i] <= '0;
            joined_q <= '0;
        end else begin
            for (int i = 0; i < NUM_STAP; i++) begin
                if (!commit_d[i]) begin
                    cnt_q[i]    <= '0;
                    joined_q[i] <= 1'b0;
                end else if (!commit_q[i]) begin
                    cnt_q[i]    <= CNT_W'(RST_CYC);
                    joined_q[i] <= 1'b0;
                end else begin
                    if (cnt_q[i] != '0)
                        cnt_q[i] <= CNT_W'(cnt_q[i] - CNT_W'(1));
                    if (safe_c && cnt_q[i] == '0)
                        joined_q[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        strst_n_c = '0;
        for (int i = 0; i < NUM_STAP; i++)
            strst_n_c[i] = ~TRST & (cnt_q[i] == '0);
    end

    assign active_c = commit_q & joined_q;
`else
    assign strst_n_c = {NUM_STAP{~TRST}};
    assign active_c  = commit_q;
`endif

    // Daisy chain in ascending index order; parked channels see TMS=0, TDI=0
    always_comb begin
        logic carry;
        carry  = jtag.TDI;
        stdi_c = '0;
        stms_c = '0;
        for (int i = 0; i < NUM_STAP; i++) begin
            if (active_c[i]) begin
                stdi_c[i] = carry;
                stms_c[i] = jtag.TMS;
                carry     = jtag.STDO[i];
            end
        end
        tdo_c = (active_c != '0) ? carry : bypass_q;
    end

    assign jtag.STCK        = {NUM_STAP{TCK}};
    assign jtag.STMS        = stms_c;
    assign jtag.STDI        = stdi_c;
    assign jtag.TDO         = tdo_c;
    assign jtag.STRST_N     = strst_n_c;
    assign jtag.active_mask = active_c;
    assign jtag.tap_state   = state_q;
    assign jtag.pending     = (req_mask != commit_q);

endmodule
